ras_ckpt_stack: RTL and testbench
=================================

Name: ras_ckpt_stack

Overview:
- Parametrised return-address stack for the frontend branch predictor, generalising the fixed RAS to arbitrary depth, address width and checkpoint/restore.
- Circular buffer of DEPTH return addresses.
- Supports push, pop and same-cycle push+pop (call replacing return).
- Snapshot/restore of stack pointer and occupancy for misprediction recovery, flush, and a saturating overflow counter for performance monitoring.

Parameters:
- DEPTH, 2, number of entries; legal range >= 2, power of two not required.
- VLEN, 64, return-address width in bits.
- CNT_W, 16, overflow counter width.
- PTR_W, max(1,$clog2(DEPTH)), derived; pointer width.
- OCC_W, $clog2(DEPTH+1), derived; occupancy width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  empty the stack.
- push_i  in  1  push addr_i (call).
- pop_i  in  1  pop top entry (return).
- addr_i  in  VLEN  address to push.
- restore_i  in  1  load pointer/occupancy from checkpoint.
- restore_ptr_i  in  PTR_W  checkpointed top pointer.
- restore_occ_i  in  OCC_W  checkpointed occupancy.
- top_o  out  VLEN  entry at top pointer.
- top_valid_o  out  1  occupancy != 0.
- full_o  out  1  occupancy == DEPTH.
- snap_ptr_o  out  PTR_W  current top pointer, for checkpointing.
- snap_occ_o  out  OCC_W  current occupancy, for checkpointing.
- ovf_cnt_o  out  CNT_W  saturating count of overwritten entries.

Behaviour:
- State: mem[DEPTH] of VLEN, tos (PTR_W), occ (OCC_W), ovf_cnt (CNT_W). All outputs are combinational from registered state. Updates are visible the cycle after the triggering edge.
- Reset (rst_i=1 at edge): tos=0, occ=0, ovf_cnt=0, all mem=0. Consequently top_o=0, top_valid_o=0, full_o=0, snap_*=0. Reset overrides every other input.
- Wrap rules:
  - inc(p) = (p==DEPTH-1) ? 0 : p+1
  - dec(p) = (p==0) ? DEPTH-1 : p-1
  - The pointer never takes values >= DEPTH.
- Priority per cycle: rst_i > flush_i > restore_i > push/pop. A lower-priority request in the same cycle is ignored.
- Flush: occ=0; tos and mem are unchanged; ovf_cnt is unchanged.
- Restore:
  - tos=restore_ptr_i.
  - occ=min(restore_occ_i, DEPTH).
  - If restore_ptr_i >= DEPTH, tos=DEPTH-1.
  - mem is unchanged.
- Push only:
  - tos=inc(tos), mem[inc(tos)]=addr_i.
  - If occ<DEPTH then occ+1; otherwise the oldest entry is overwritten, occ stays DEPTH, and ovf_cnt increments unless it is all-ones (saturating).
- Pop only:
  - If occ>0: tos=dec(tos), occ-1.
  - If occ==0: no state change (underflow is ignored and top_o content is not meaningful).
- Push and pop together:
  - If occ>0: mem[tos]=addr_i; tos and occ unchanged.
  - If occ==0: behaves exactly as push only.
- top_o=mem[tos] regardless of occ. Consumers qualify it with top_valid_o.
- Checkpoint restore is exact only while entries between checkpoint and restore were not overwritten. Content corruption after overflow is architecturally acceptable (prediction only).

Test Plan:
- Reset, then push 0x1000, 0x2000 (DEPTH=2) -> top_o=0x2000, occ=2, full_o=1, tos=0 (wrapped), ovf_cnt_o=0.
- Continuing, push 0x3000 -> top_o=0x3000, occ stays 2, ovf_cnt_o=1. Then pop twice -> top_o=0x2000 then top_valid_o=0.
- Empty stack, pop_i=1 for 3 cycles -> tos, occ, top_valid_o unchanged (0); no wrap.
- Push 0xA0, then push+pop with 0xB0 -> top_o=0xB0, occ=1, tos unchanged. Push+pop on an empty stack with 0xC0 -> occ=1, top_o=0xC0.
- Snapshot after push 0x10 (snap_ptr=1, snap_occ=1); push 0x20, pop, pop; then restore_i with the snapshot values -> top_o=0x10, occ=1. Same-cycle restore_i+push_i -> push ignored.
- Occupancy 2 with flush_i+push_i asserted together -> occ=0, top_valid_o=0, mem unchanged. rst_i mid-sequence -> all outputs 0 the next cycle. Push with CNT_W=2 and ovf_cnt=3 -> counter holds at 3.

Source files
------------

// File: rtl/ras_ckpt_stack.sv
// Return-address stack: circular buffer with push/pop/replace, checkpoint
// restore of pointer and occupancy, flush, and a saturating overflow counter.
module ras_ckpt_stack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [VLEN-1:0]  addr_i,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [OCC_W-1:0] restore_occ_i,
    output logic [VLEN-1:0]  top_o,
    output logic             top_valid_o,
    output logic             full_o,
    output logic [PTR_W-1:0] snap_ptr_o,
    output logic [OCC_W-1:0] snap_occ_o,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [VLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] ovf_cnt;

    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;
    logic [PTR_W-1:0] tos_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic [CNT_W-1:0] ovf_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             is_full;

    assign empty   = (occ == '0);
    assign is_full = (occ == FULL_OCC);

    // Wrapping pointer neighbours; the pointer never leaves [0, DEPTH-1].
    assign tos_inc = (tos == LAST_PTR) ? '0 : tos + PTR_W'(1);
    assign tos_dec = (tos == '0) ? LAST_PTR : tos - PTR_W'(1);

    // Next-state selection in priority order: flush, restore, push/pop.
    always_comb begin
        tos_nxt = tos;
        occ_nxt = occ;
        ovf_nxt = ovf_cnt;
        wr_en   = 1'b0;
        wr_ptr  = tos;
        if (flush_i) begin
            occ_nxt = '0;
        end else if (restore_i) begin
            tos_nxt = (restore_ptr_i > LAST_PTR) ? LAST_PTR : restore_ptr_i;
            occ_nxt = (restore_occ_i > FULL_OCC) ? FULL_OCC : restore_occ_i;
        end else if (push_i && pop_i && !empty) begin
            // Call replacing a return: overwrite the top in place.
            wr_en  = 1'b1;
            wr_ptr = tos;
        end else if (push_i) begin
            tos_nxt = tos_inc;
            wr_en   = 1'b1;
            wr_ptr  = tos_inc;
            if (!is_full) begin
                occ_nxt = occ + OCC_W'(1);
            end else if (!(&ovf_cnt)) begin
                ovf_nxt = ovf_cnt + CNT_W'(1);
            end
        end else if (pop_i && !empty) begin
            tos_nxt = tos_dec;
            occ_nxt = occ - OCC_W'(1);
        end
    end

    // State and entry storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos     <= '0;
            occ     <= '0;
            ovf_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            tos     <= tos_nxt;
            occ     <= occ_nxt;
            ovf_cnt <= ovf_nxt;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_ptr == PTR_W'(i))) begin
                    mem[PTR_W'(i)] <= addr_i;
                end
            end
        end
    end

    assign top_o       = mem[tos];
    assign top_valid_o = !empty;
    assign full_o      = is_full;
    assign snap_ptr_o  = tos;
    assign snap_occ_o  = occ;
    assign ovf_cnt_o   = ovf_cnt;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Scoreboard bench for ras_ckpt_stack (DEPTH=2, CNT_W=2): directed steps queue
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_ras_ckpt_stack;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned VLEN  = 64;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned PTR_W = 1;
    localparam int unsigned OCC_W = 2;

    typedef struct {
        string            name;
        logic [VLEN-1:0]  top;
        logic             valid;
        logic             full;
        logic [PTR_W-1:0] ptr;
        logic [OCC_W-1:0] occ;
        logic [CNT_W-1:0] ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_i, flush_i, push_i, pop_i, restore_i;
    logic [VLEN-1:0]  addr_i;
    logic [PTR_W-1:0] restore_ptr_i;
    logic [OCC_W-1:0] restore_occ_i;
    logic [VLEN-1:0]  top_o;
    logic             top_valid_o, full_o;
    logic [PTR_W-1:0] snap_ptr_o;
    logic [OCC_W-1:0] snap_occ_o;
    logic [CNT_W-1:0] ovf_cnt_o;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    ras_ckpt_stack #(.DEPTH(DEPTH), .VLEN(VLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i),
        .pop_i(pop_i), .addr_i(addr_i), .restore_i(restore_i),
        .restore_ptr_i(restore_ptr_i), .restore_occ_i(restore_occ_i),
        .top_o(top_o), .top_valid_o(top_valid_o), .full_o(full_o),
        .snap_ptr_o(snap_ptr_o), .snap_occ_o(snap_occ_o), .ovf_cnt_o(ovf_cnt_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then queue the state expected after the edge.
    task automatic step(input string name,
                        input logic rst, input logic flush,
                        input logic rest, input logic [PTR_W-1:0] rptr,
                        input logic [OCC_W-1:0] rocc,
                        input logic push, input logic pop, input logic [VLEN-1:0] addr,
                        input logic [VLEN-1:0] e_top, input logic e_valid,
                        input logic e_full, input logic [PTR_W-1:0] e_ptr,
                        input logic [OCC_W-1:0] e_occ, input logic [CNT_W-1:0] e_ovf);
        exp_t e;
        @(negedge clk);
        rst_i = rst; flush_i = flush; restore_i = rest;
        restore_ptr_i = rptr; restore_occ_i = rocc;
        push_i = push; pop_i = pop; addr_i = addr;
        @(posedge clk);
        #1;
        e.name = name; e.top = e_top; e.valid = e_valid; e.full = e_full;
        e.ptr = e_ptr; e.occ = e_occ; e.ovf = e_ovf;
        exp_q.push_back(e);
        rst_i = 1'b0; flush_i = 1'b0; restore_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    endtask

    // Monitor: outputs are stable away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (top_o !== e.top || top_valid_o !== e.valid || full_o !== e.full ||
                snap_ptr_o !== e.ptr || snap_occ_o !== e.occ || ovf_cnt_o !== e.ovf) begin
                bad++;
                $display("FAIL %s: got top=%h v=%b f=%b ptr=%0d occ=%0d ovf=%0d, want top=%h v=%b f=%b ptr=%0d occ=%0d ovf=%0d",
                         e.name, top_o, top_valid_o, full_o, snap_ptr_o, snap_occ_o, ovf_cnt_o,
                         e.top, e.valid, e.full, e.ptr, e.occ, e.ovf);
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; restore_i = 1'b0;
        addr_i = '0; restore_ptr_i = '0; restore_occ_i = '0;

        //    name            rst flu rst rptr rocc psh pop addr      top      v  f  ptr occ ovf
        step("reset",          1, 0, 0, 0, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 0, 0);
        step("push_1000",      0, 0, 0, 0, 0, 1, 0, 64'h1000, 64'h1000, 1, 0, 1, 1, 0);
        step("push_2000_wrap", 0, 0, 0, 0, 0, 1, 0, 64'h2000, 64'h2000, 1, 1, 0, 2, 0);
        step("push_3000_ovf",  0, 0, 0, 0, 0, 1, 0, 64'h3000, 64'h3000, 1, 1, 1, 2, 1);
        step("pop_a",          0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h2000, 1, 0, 0, 1, 1);
        step("pop_b_empty",    0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h3000, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            step("underflow_pop", 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h3000, 0, 0, 1, 0, 1);

        step("reset2",         1, 0, 0, 0, 0, 1, 1, 64'hFF,   64'h0,    0, 0, 0, 0, 0);
        step("push_A0",        0, 0, 0, 0, 0, 1, 0, 64'hA0,   64'hA0,   1, 0, 1, 1, 0);
        step("pushpop_B0",     0, 0, 0, 0, 0, 1, 1, 64'hB0,   64'hB0,   1, 0, 1, 1, 0);
        step("pop_to_empty",   0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h0,    0, 0, 0, 0, 0);
        step("pushpop_empty",  0, 0, 0, 0, 0, 1, 1, 64'hC0,   64'hC0,   1, 0, 1, 1, 0);

        step("reset3",         1, 0, 0, 0, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 0, 0);
        step("push_10_snap",   0, 0, 0, 0, 0, 1, 0, 64'h10,   64'h10,   1, 0, 1, 1, 0);
        step("push_20",        0, 0, 0, 0, 0, 1, 0, 64'h20,   64'h20,   1, 1, 0, 2, 0);
        step("pop_c",          0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h10,   1, 0, 1, 1, 0);
        step("pop_d",          0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h20,   0, 0, 0, 0, 0);
        step("restore_snap",   0, 0, 1, 1, 1, 0, 0, 64'h0,    64'h10,   1, 0, 1, 1, 0);
        step("restore_w_push", 0, 0, 1, 0, 2, 1, 0, 64'h99,   64'h20,   1, 1, 0, 2, 0);
        step("restore_clamp",  0, 0, 1, 1, 3, 0, 0, 64'h0,    64'h10,   1, 1, 1, 2, 0);
        step("flush_w_push",   0, 1, 0, 0, 0, 1, 0, 64'h77,   64'h10,   0, 0, 1, 0, 0);
        step("restore_mem",    0, 0, 1, 1, 2, 0, 0, 64'h0,    64'h10,   1, 1, 1, 2, 0);
        step("pop_mem0",       0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h20,   1, 0, 0, 1, 0);
        step("flush_w_rest",   0, 1, 1, 1, 2, 0, 0, 64'h0,    64'h20,   0, 0, 0, 0, 0);

        step("sat_push1",      0, 0, 0, 0, 0, 1, 0, 64'h1,    64'h1,    1, 0, 1, 1, 0);
        step("sat_push2",      0, 0, 0, 0, 0, 1, 0, 64'h2,    64'h2,    1, 1, 0, 2, 0);
        step("sat_push3",      0, 0, 0, 0, 0, 1, 0, 64'h3,    64'h3,    1, 1, 1, 2, 1);
        step("sat_push4",      0, 0, 0, 0, 0, 1, 0, 64'h4,    64'h4,    1, 1, 0, 2, 2);
        step("sat_push5",      0, 0, 0, 0, 0, 1, 0, 64'h5,    64'h5,    1, 1, 1, 2, 3);
        step("sat_hold",       0, 0, 0, 0, 0, 1, 0, 64'h6,    64'h6,    1, 1, 0, 2, 3);
        step("pushpop_full",   0, 0, 0, 0, 0, 1, 1, 64'h7,    64'h7,    1, 1, 0, 2, 3);
        step("reset_mid",      1, 1, 1, 1, 2, 1, 0, 64'h8,    64'h0,    0, 0, 0, 0, 0);
        step("pop_after_rst",  0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h0,    0, 0, 0, 0, 0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
